pipeline_stall_controller: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline registers (PC, IF/ID, ID/EX, ...).
//  - Detects RAW data hazards from Tuse/Tnew and tracks the multiply/divide unit busy window.
//  - Drives the enable of PC and IF/ID, and the bubble-insert (clear) of ID/EX.
//  - Keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_stall_controller.sv | 137 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Detects RAW hazards from Tuse/Tnew, tracks the mult/div busy window,
// drives PC / IF-ID enables and the ID-EX bubble, and counts stalled cycles.
module pipeline_stall_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_WIDTH   = 4,
  parameter int PERF_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            d_rs_addr,
  input  logic [4:0]            d_rt_addr,
  input  logic [1:0]            d_rs_tuse,
  input  logic [1:0]            d_rt_tuse,
  input  logic                  d_is_md,
  input  logic [4:0]            e_dst_addr,
  input  logic [1:0]            e_tnew,
  input  logic [4:0]            m_dst_addr,
  input  logic [1:0]            m_tnew,
  input  logic                  e_md_start,
  input  logic                  e_md_is_div,
  output logic                  stall,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  de_clr,
  output logic                  md_busy,
  output logic [PERF_WIDTH-1:0] stall_cycles
);

  // Remaining busy cycles of the mult/div unit; zero means idle.
  logic [CNT_WIDTH-1:0]  busy_q;
  logic [CNT_WIDTH-1:0]  busy_d;
  // Saturating stall-cycle counter.
  logic [PERF_WIDTH-1:0] perf_q;
  logic [PERF_WIDTH-1:0] perf_d;

  logic data_hazard_s;
  logic md_hazard_s;
  logic busy_nz_s;
  logic stall_raw_s;

  // A source register conflicts with a producer when it names the same
  // non-zero register and the consumer needs it before the producer has it.
  // Register 0 is hard-wired, so it never creates a dependency; a tuse of 3
  // can never be below a 2-bit tnew, so "unused" sources fall out naturally.
  function automatic logic src_hazard(
    input logic [4:0] src_addr,
    input logic [1:0] src_tuse,
    input logic [4:0] dst_addr,
    input logic [1:0] dst_tnew
  );
    logic hit;
    if ((src_addr != 5'd0) && (src_addr == dst_addr) && (src_tuse < dst_tnew)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // Hazard detection: data dependencies against E and M, plus mult/div occupancy.
  always_comb begin
    data_hazard_s = src_hazard(d_rs_addr, d_rs_tuse, e_dst_addr, e_tnew) |
                    src_hazard(d_rs_addr, d_rs_tuse, m_dst_addr, m_tnew) |
                    src_hazard(d_rt_addr, d_rt_tuse, e_dst_addr, e_tnew) |
                    src_hazard(d_rt_addr, d_rt_tuse, m_dst_addr, m_tnew);
    busy_nz_s     = (busy_q != {CNT_WIDTH{1'b0}});
    // A start in E this cycle counts as busy for D, so the md instruction
    // behind it waits through the start cycle as well.
    md_hazard_s   = d_is_md & (busy_nz_s | e_md_start);
    stall_raw_s   = data_hazard_s | md_hazard_s;
  end

  // Pipeline control outputs; reset forces the pipeline to free-run.
  always_comb begin
    stall   = 1'b0;
    pc_en   = 1'b1;
    fd_en   = 1'b1;
    de_clr  = 1'b0;
    md_busy = 1'b0;
    if (reset) begin
      stall   = 1'b0;
      pc_en   = 1'b1;
      fd_en   = 1'b1;
      de_clr  = 1'b0;
      md_busy = 1'b0;
    end else begin
      stall   = stall_raw_s;
      pc_en   = ~stall_raw_s;
      fd_en   = ~stall_raw_s;
      de_clr  = stall_raw_s;
      md_busy = busy_nz_s;
    end
  end

  // Next busy count: a new start always reloads, even at the tail of a
  // previous operation, so back-to-back operations keep md_busy continuous.
  always_comb begin
    busy_d = busy_q;
    if (e_md_start) begin
      if (e_md_is_div) begin
        busy_d = CNT_WIDTH'(DIV_CYCLES);
      end else begin
        busy_d = CNT_WIDTH'(MULT_CYCLES);
      end
    end else if (busy_nz_s) begin
      busy_d = busy_q - CNT_WIDTH'(1);
    end else begin
      busy_d = {CNT_WIDTH{1'b0}};
    end
  end

  // Next stall count: increment on stalled cycles, hold at all-ones.
  always_comb begin
    perf_d = perf_q;
    if (stall_raw_s && (perf_q != {PERF_WIDTH{1'b1}})) begin
      perf_d = perf_q + PERF_WIDTH'(1);
    end else begin
      perf_d = perf_q;
    end
  end

  // State registers; reset abandons any in-flight mult/div count at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= {CNT_WIDTH{1'b0}};
      perf_q <= {PERF_WIDTH{1'b0}};
    end else begin
      busy_q <= busy_d;
      perf_q <= perf_d;
    end
  end

  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed, table-driven bench for pipeline_stall_controller.
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset3;
  logic [4:0]  d_rs_addr, d_rt_addr, e_dst_addr, m_dst_addr;
  logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_is_div;
  logic        stall, pc_en, fd_en, de_clr, md_busy;
  logic [31:0] stall_cycles;
  logic        stall3, pc_en3, fd_en3, de_clr3, md_busy3;
  logic [2:0]  stall_cycles3;

  int errors = 0;
  int checks = 0;
  int exp_sc = 0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic [4:0] e_dst;
    logic [1:0] e_tnew;
    logic [4:0] m_dst;
    logic [1:0] m_tnew;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  pipeline_stall_controller u_dut (
    .clk(clk), .reset(reset),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_is_md(d_is_md),
    .e_dst_addr(e_dst_addr), .e_tnew(e_tnew),
    .m_dst_addr(m_dst_addr), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  pipeline_stall_controller #(.PERF_WIDTH(3)) u_dut3 (
    .clk(clk), .reset(reset3),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_is_md(d_is_md),
    .e_dst_addr(e_dst_addr), .e_tnew(e_tnew),
    .m_dst_addr(m_dst_addr), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .stall(stall3), .pc_en(pc_en3), .fd_en(fd_en3), .de_clr(de_clr3),
    .md_busy(md_busy3), .stall_cycles(stall_cycles3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Check all control outputs of the main instance for an expected stall value.
  task automatic chk_ctrl(input string name, input logic es, input logic eb);
    chk({name, ".stall"},   32'(stall),   32'(es));
    chk({name, ".pc_en"},   32'(pc_en),   32'(!es));
    chk({name, ".fd_en"},   32'(fd_en),   32'(!es));
    chk({name, ".de_clr"},  32'(de_clr),  32'(es));
    chk({name, ".md_busy"}, 32'(md_busy), 32'(eb));
  endtask

  // Advance one clock; the model counter follows the expected stall value.
  task automatic cycle(input logic es);
    @(posedge clk);
    if (reset) exp_sc = 0;
    else if (es) exp_sc++;
    #1;
  endtask

  task automatic quiet();
    d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
    e_dst_addr = 5'd0; e_tnew = 2'd0; m_dst_addr = 5'd0; m_tnew = 2'd0;
    d_is_md = 1'b0; e_md_start = 1'b0; e_md_is_div = 1'b0;
  endtask

  initial begin
    //                rs     rt     rsT   rtT   eDst   eTn   mDst   mTn   stall
    vecs[0] = '{5'd8,  5'd1,  2'd0, 2'd3, 5'd8,  2'd1, 5'd0,  2'd0, 1'b1};
    vecs[1] = '{5'd0,  5'd1,  2'd0, 2'd3, 5'd8,  2'd1, 5'd0,  2'd0, 1'b0};
    vecs[2] = '{5'd2,  5'd5,  2'd3, 2'd1, 5'd0,  2'd0, 5'd5,  2'd1, 1'b0};
    vecs[3] = '{5'd2,  5'd5,  2'd3, 2'd1, 5'd0,  2'd0, 5'd5,  2'd2, 1'b1};
    vecs[4] = '{5'd6,  5'd1,  2'd3, 2'd3, 5'd6,  2'd3, 5'd0,  2'd0, 1'b0};
    vecs[5] = '{5'd6,  5'd1,  2'd2, 2'd3, 5'd6,  2'd3, 5'd0,  2'd0, 1'b1};
    vecs[6] = '{5'd0,  5'd0,  2'd0, 2'd0, 5'd0,  2'd3, 5'd0,  2'd3, 1'b0};
    vecs[7] = '{5'd3,  5'd1,  2'd0, 2'd3, 5'd4,  2'd3, 5'd2,  2'd3, 1'b0};
    vecs[8] = '{5'd1,  5'd7,  2'd3, 2'd0, 5'd7,  2'd0, 5'd0,  2'd0, 1'b0};
    vecs[9] = '{5'd9,  5'd1,  2'd1, 2'd3, 5'd0,  2'd0, 5'd9,  2'd2, 1'b1};

    // Reset held with a start and both hazard kinds present.
    quiet();
    reset = 1'b1; reset3 = 1'b1;
    e_md_start = 1'b1; d_is_md = 1'b1;
    d_rs_addr = 5'd8; d_rs_tuse = 2'd0; e_dst_addr = 5'd8; e_tnew = 2'd1;
    #2;
    chk_ctrl("rst0", 1'b0, 1'b0);
    cycle(1'b0);
    chk_ctrl("rst1", 1'b0, 1'b0);
    cycle(1'b0);
    reset = 1'b0;
    quiet();
    #1;
    chk_ctrl("post_rst", 1'b0, 1'b0);
    chk("post_rst.stall_cycles", stall_cycles, 32'd0);

    // Combinational hazard table.
    for (int i = 0; i < 10; i++) begin
      d_rs_addr = vecs[i].rs;   d_rt_addr = vecs[i].rt;
      d_rs_tuse = vecs[i].rs_tuse; d_rt_tuse = vecs[i].rt_tuse;
      e_dst_addr = vecs[i].e_dst; e_tnew = vecs[i].e_tnew;
      m_dst_addr = vecs[i].m_dst; m_tnew = vecs[i].m_tnew;
      #1;
      chk($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_stall);
      checks--; // the line above only names the vector; real checks follow
      chk_ctrl($sformatf("vec%0d", i), vecs[i].exp_stall, 1'b0);
      cycle(vecs[i].exp_stall);
    end
    quiet();
    #1;
    chk("table.stall_cycles", stall_cycles, 32'd4);

    // Mult start followed by an md instruction held in D.
    e_md_start = 1'b1; e_md_is_div = 1'b0; d_is_md = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk_ctrl($sformatf("mult_c%0d", c), (c < 6), (c >= 1 && c <= 5));
      cycle(c < 6);
      e_md_start = 1'b0;
    end
    quiet();
    #1;
    chk("mult.stall_cycles", stall_cycles, 32'(exp_sc));

    // Div then a mult started at the last busy cycle: busy stays continuous.
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    for (int c = 0; c < 17; c++) begin
      #1;
      chk($sformatf("chain_c%0d.md_busy", c), 32'(md_busy), 32'(c >= 1 && c <= 15));
      chk($sformatf("chain_c%0d.stall", c), 32'(stall), 32'd0);
      cycle(1'b0);
      e_md_start = (c == 9);
      e_md_is_div = 1'b0;
    end
    quiet();

    // Reset in the middle of a divide drops the busy window immediately.
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    cycle(1'b0);
    quiet();
    cycle(1'b0);
    cycle(1'b0);
    #1;
    chk("middiv.md_busy", 32'(md_busy), 32'd1);
    reset = 1'b1; d_is_md = 1'b1;
    #1;
    chk_ctrl("middiv_rst", 1'b0, 1'b0);
    cycle(1'b0);
    reset = 1'b0; d_is_md = 1'b0;
    #1;
    chk_ctrl("middiv_after", 1'b0, 1'b0);
    chk("middiv_after.stall_cycles", stall_cycles, 32'd0);

    // Saturation of a 3-bit counter under a persistent hazard.
    d_rs_addr = 5'd8; d_rs_tuse = 2'd0; e_dst_addr = 5'd8; e_tnew = 2'd1;
    #1;
    chk("sat_rst.stall3", 32'(stall3), 32'd0);
    cycle(1'b1);
    reset3 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("sat_c%0d.stall3", c), 32'(stall3), 32'd1);
      cycle(1'b1);
      chk($sformatf("sat_c%0d.stall_cycles3", c), 32'(stall_cycles3),
          32'((c + 1 > 7) ? 7 : c + 1));
    end
    chk("main.stall_cycles", stall_cycles, 32'(exp_sc));
    reset3 = 1'b1;
    cycle(1'b1);
    chk("sat_rst_again.stall_cycles3", 32'(stall_cycles3), 32'd0);
    quiet();
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
